// File: rtl/tt3_pkg.sv
// Shared types and constants for the 3-input truth-table sweeper.
package tt3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    CAPTURE,
    NEXT,
    DONE
  } tt3_state_t;

  localparam int unsigned TT3_ROWS = 8;
  localparam logic [7:0] TT3_DEFAULT_CODE = 8'h78;

  // Row index to {in1,in2,in3}; row bit 2 drives in1.
  function automatic logic [2:0] tt3_row_inputs(input logic [2:0] row);
    return row;
  endfunction

endpackage

// File: rtl/tt3_sweep_if.sv
// Sweeper-to-circuit signal bundle; master is the sweeper side.
interface tt3_sweep_if;
  logic       start;
  logic       loop;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] captured;
  logic       match;
  logic [7:0] mismatch_mask;

  modport master (
    input  start, loop, dut_out,
    output in1, in2, in3, busy, done, captured, match, mismatch_mask
  );

  modport slave (
    output start, loop, dut_out,
    input  in1, in2, in3, busy, done, captured, match, mismatch_mask
  );
endinterface

// File: rtl/tt3_sync2.sv
// Two-flop synchronizer with asynchronous active-high clear.
module tt3_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/tt3_sweep.sv
// Drives all eight input rows of a 3-input circuit, samples its output
// after a settle window and compares the measured code with EXPECTED.
module tt3_sweep
  import tt3_pkg::*;
#(
  parameter logic [7:0]  EXPECTED = TT3_DEFAULT_CODE,
  parameter int unsigned SETTLE   = 4
) (
  input logic         clk,
  input logic         rst,
  tt3_sweep_if.master bus
);
  localparam int unsigned   CW        = $clog2(SETTLE + 3);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SETTLE);
  localparam logic [2:0]    ROW_LAST  = 3'(TT3_ROWS - 1);

  tt3_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    row;
  logic [7:0]    shift;
  logic          sample;
  logic          sweep_begin;
  logic          busy_d;
  logic          done_d;

  tt3_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.dut_out),
    .q   (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= busy_d;
      bus.done <= done_d;
    end
  end

  // APPLY holds SETTLE+1 cycles and CAPTURE one more, giving SETTLE+2 per
  // row; NEXT adds the single gap cycle between the last capture and DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = APPLY;
      APPLY:   if (cnt == HOLD_LAST) state_next = CAPTURE;
      CAPTURE: state_next = (row == ROW_LAST) ? NEXT : APPLY;
      NEXT:    state_next = DONE;
      DONE:    state_next = bus.loop ? APPLY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sweep_begin = (state_next == APPLY) && ((state == IDLE) || (state == DONE));
    done_d      = (state_next == DONE);
    busy_d      = (state_next == APPLY) || (state_next == CAPTURE) ||
                  (state_next == NEXT)  || ((state_next == DONE) && bus.loop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                         <= '0;
      row                         <= '0;
      shift                       <= '0;
      {bus.in1, bus.in2, bus.in3} <= '0;
      bus.captured                <= '0;
      bus.match                   <= (EXPECTED == 8'h00);
      bus.mismatch_mask           <= EXPECTED;
    end else begin
      if (sweep_begin) begin
        cnt                         <= '0;
        row                         <= '0;
        shift                       <= '0;
        {bus.in1, bus.in2, bus.in3} <= tt3_row_inputs(3'd0);
      end else if (state == APPLY) begin
        cnt <= cnt + 1'b1;
      end else if (state == CAPTURE) begin
        shift <= {shift[6:0], sample};
        cnt   <= '0;
        if (row != ROW_LAST) begin
          row                         <= row + 3'd1;
          {bus.in1, bus.in2, bus.in3} <= tt3_row_inputs(row + 3'd1);
        end
      end else if (state == DONE) begin
        {bus.in1, bus.in2, bus.in3} <= tt3_row_inputs(3'd0);
      end

      if (state == NEXT) begin
        bus.captured      <= shift;
        bus.match         <= (shift == EXPECTED);
        bus.mismatch_mask <= shift ^ EXPECTED;
      end
    end
  end
endmodule

// File: tb/tb_tt3_sweep.sv
// Directed bench for tt3_sweep: behavioural circuit models feed dut_out.
module tb_tt3_sweep;
  logic clk = 1'b0;
  logic rst;
  int   mode_a;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] dly_a, dly_b;
  logic f_a, f_b;

  always #5 clk = ~clk;

  tt3_sweep_if ia ();
  tt3_sweep_if ib ();

  tt3_sweep #(.EXPECTED(8'h78), .SETTLE(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  tt3_sweep #(.EXPECTED(8'h78), .SETTLE(1)) u_b (.clk(clk), .rst(rst), .bus(ib));

  assign f_a = ia.in1 ^ (ia.in2 | ia.in3);
  assign f_b = ib.in1 ^ (ib.in2 | ib.in3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_a <= '0;
      dly_b <= '0;
    end else begin
      dly_a <= {dly_a[6:0], f_a};
      dly_b <= {dly_b[6:0], f_b};
    end
  end

  // mode 0: zero delay, 1: stuck 0, 2: stuck 1, 3: three-cycle delay
  assign ia.dut_out = (mode_a == 0) ? f_a :
                      (mode_a == 1) ? 1'b0 :
                      (mode_a == 2) ? 1'b1 : dly_a[2];
  assign ib.dut_out = dly_b[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start edge is cycle 1; returns the cycle of the first done and done count.
  task automatic run_a(input bit repulse, output int first, output int ndone);
    first = 0;
    ndone = 0;
    ia.start = 1'b1;
    tick;
    ia.start = 1'b0;
    for (int c = 2; c <= 80; c++) begin
      ia.start = repulse && (c == 10 || c == 30);
      tick;
      if (ia.done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
  endtask

  initial begin
    int first, ndone, busy_low, prev_done;
    int t[4];
    rst = 1'b1;
    mode_a = 0;
    ia.start = 1'b0; ia.loop = 1'b0;
    ib.start = 1'b0; ib.loop = 1'b0;
    tick; tick;
    chk("rst_in", {29'd0, ia.in1, ia.in2, ia.in3}, 32'd0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_captured", ia.captured, 32'h00);
    chk("rst_mask", ia.mismatch_mask, 32'h78);
    chk("rst_match", ia.match, 0);
    rst = 1'b0;
    tick;

    run_a(1'b0, first, ndone);
    chk("ideal_done_cycle", first, 50);
    chk("ideal_done_count", ndone, 1);
    chk("ideal_captured", ia.captured, 32'h78);
    chk("ideal_match", ia.match, 1);
    chk("ideal_mask", ia.mismatch_mask, 32'h00);
    chk("ideal_busy_after", ia.busy, 0);

    mode_a = 1;
    run_a(1'b0, first, ndone);
    chk("stuck0_captured", ia.captured, 32'h00);
    chk("stuck0_match", ia.match, 0);
    chk("stuck0_mask", ia.mismatch_mask, 32'h78);

    mode_a = 2;
    run_a(1'b0, first, ndone);
    chk("stuck1_captured", ia.captured, 32'hFF);
    chk("stuck1_match", ia.match, 0);
    chk("stuck1_mask", ia.mismatch_mask, 32'h87);

    mode_a = 3;
    run_a(1'b0, first, ndone);
    chk("delay3_captured", ia.captured, 32'h78);
    chk("delay3_match", ia.match, 1);

    ib.start = 1'b1;
    tick;
    ib.start = 1'b0;
    ndone = 0;
    for (int c = 2; c <= 40; c++) begin
      tick;
      if (ib.done) ndone++;
    end
    chk("slow_done_count", ndone, 1);
    chk("slow_match", ib.match, 0);
    chk("slow_mask_nonzero", ib.mismatch_mask != 8'h00, 1);
    chk("slow_captured", ib.captured, 32'h0F);

    mode_a = 0;
    ia.start = 1'b1;
    tick;
    ia.start = 1'b0;
    for (int c = 2; c <= 20; c++) tick;
    chk("pre_abort_busy", ia.busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_in", {29'd0, ia.in1, ia.in2, ia.in3}, 32'd0);
    chk("abort_busy", ia.busy, 0);
    chk("abort_done", ia.done, 0);
    chk("abort_captured", ia.captured, 32'h00);
    chk("abort_mask", ia.mismatch_mask, 32'h78);
    chk("abort_match", ia.match, 0);
    tick;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (ia.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_a(1'b1, first, ndone);
    chk("repulse_done_cycle", first, 50);
    chk("repulse_done_count", ndone, 1);
    chk("repulse_captured", ia.captured, 32'h78);

    ia.loop = 1'b1;
    ia.start = 1'b1;
    tick;
    ia.start = 1'b0;
    ndone = 0;
    busy_low = 0;
    prev_done = 0;
    for (int c = 2; c <= 160; c++) begin
      tick;
      if (!ia.busy) busy_low++;
      if (prev_done != 0)
        chk("loop_row0_after_done", {29'd0, ia.in1, ia.in2, ia.in3}, 32'd0);
      if (ia.done) begin
        if (ndone < 4) t[ndone] = c;
        ndone++;
        chk("loop_row7_at_done", {29'd0, ia.in1, ia.in2, ia.in3}, 32'd7);
      end
      prev_done = ia.done ? 1 : 0;
    end
    chk("loop_done_count", ndone, 3);
    chk("loop_busy_low_cycles", busy_low, 0);
    chk("loop_done1", t[0], 50);
    chk("loop_gap12", t[1] - t[0], 50);
    chk("loop_gap23", t[2] - t[1], 50);
    chk("loop_captured", ia.captured, 32'h78);

    ia.loop = 1'b0;
    ndone = 0;
    for (int c = 161; c <= 220; c++) begin
      tick;
      if (ia.done) ndone++;
    end
    chk("loop_exit_done_count", ndone, 1);
    chk("loop_exit_busy", ia.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
